// File: rtl/oldland_exc_ctrl.sv
// Exception/IRQ entry sequencer for the Oldland pipeline: arbitrates aborts, illegal
// instructions and IRQs, drains the pipeline, pulses entry into execute and redirects fetch.
module oldland_exc_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        irq_req,
    input  logic        irqs_enabled,
    input  logic        dbg_halt,
    input  logic        data_abort,
    input  logic [31:0] data_pc_plus_4,
    input  logic        instr_abort,
    input  logic        illegal_instr,
    input  logic        i_valid,
    input  logic [31:0] dec_pc_plus_4,
    input  logic [31:0] irq_pc,
    input  logic [25:0] vector_base,
    input  logic        redirect_ack,
    output logic        flush,
    output logic        busy,
    output logic        exception_start,
    output logic        irq_start,
    output logic        exception_disable_irqs,
    output logic [31:0] irq_fault_address,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [2:0]  exc_cause
);

    typedef enum logic [1:0] {IDLE, DRAIN, ENTER, REDIRECT} state_t;

    localparam logic [2:0] CAUSE_NONE    = 3'd0;
    localparam logic [2:0] CAUSE_ILLEGAL = 3'd1;
    localparam logic [2:0] CAUSE_IRQ     = 3'd3;
    localparam logic [2:0] CAUSE_IABORT  = 3'd4;
    localparam logic [2:0] CAUSE_DABORT  = 3'd5;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             from_enter;
    logic             irq_hold;
    logic             load;
    logic [2:0]       new_cause;
    logic [31:0]      new_fault;

    function automatic logic [5:0] vec_offset(input logic [2:0] cause);
        case (cause)
            CAUSE_ILLEGAL: vec_offset = 6'h04;
            CAUSE_IRQ:     vec_offset = 6'h0c;
            CAUSE_IABORT:  vec_offset = 6'h10;
            CAUSE_DABORT:  vec_offset = 6'h14;
            default:       vec_offset = 6'h00;
        endcase
    endfunction

    // irq_hold masks IRQ for the first IDLE cycle after a fast return, while
    // execute's irqs_enabled has not yet caught up with exception_disable_irqs.
    always_comb begin
        new_cause = CAUSE_NONE;
        new_fault = irq_pc;
        if (data_abort) begin
            new_cause = CAUSE_DABORT;
            new_fault = data_pc_plus_4;
        end else if (instr_abort && i_valid) begin
            new_cause = CAUSE_IABORT;
            new_fault = dec_pc_plus_4;
        end else if (illegal_instr && i_valid) begin
            new_cause = CAUSE_ILLEGAL;
            new_fault = dec_pc_plus_4;
        end else if (irq_req && irqs_enabled && !dbg_halt && !irq_hold) begin
            new_cause = CAUSE_IRQ;
            new_fault = irq_pc;
        end
    end

    // A data abort during drain belongs to an older instruction and takes over.
    assign load = ((state == IDLE) && (new_cause != CAUSE_NONE)) ||
                  ((state == DRAIN) && data_abort && (exc_cause != CAUSE_DABORT));

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                  <= IDLE;
            cnt                    <= '0;
            from_enter             <= 1'b0;
            irq_hold               <= 1'b0;
            flush                  <= 1'b0;
            exception_start        <= 1'b0;
            irq_start              <= 1'b0;
            exception_disable_irqs <= 1'b0;
            redirect_valid         <= 1'b0;
            redirect_pc            <= '0;
            irq_fault_address      <= '0;
            exc_cause              <= CAUSE_NONE;
        end else begin
            exception_start        <= 1'b0;
            irq_start              <= 1'b0;
            exception_disable_irqs <= 1'b0;
            irq_hold               <= 1'b0;
            from_enter             <= (state == ENTER);
            if (load) begin
                exc_cause         <= new_cause;
                redirect_pc       <= {vector_base, vec_offset(new_cause)};
                irq_fault_address <= new_fault;
                cnt               <= DRAIN_LOAD;
                flush             <= 1'b1;
                state             <= DRAIN;
            end else begin
                case (state)
                    IDLE: ;
                    DRAIN: begin
                        if (cnt == '0) begin
                            state                  <= ENTER;
                            exception_start        <= (exc_cause != CAUSE_IRQ);
                            irq_start              <= (exc_cause == CAUSE_IRQ);
                            exception_disable_irqs <= 1'b1;
                            redirect_valid         <= 1'b1;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    ENTER: begin
                        flush <= 1'b0;
                        if (redirect_ack) begin
                            redirect_valid <= 1'b0;
                            irq_hold       <= 1'b1;
                            state          <= IDLE;
                        end else begin
                            state <= REDIRECT;
                        end
                    end
                    REDIRECT: begin
                        if (redirect_ack) begin
                            redirect_valid <= 1'b0;
                            irq_hold       <= from_enter;
                            state          <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/oldland_exc_ctrl.md
Name: oldland_exc_ctrl

Overview:
- Exception/interrupt entry sequencer for the Oldland pipeline; sits beside the execute stage.
- Arbitrates data abort, instruction abort, illegal instruction and external IRQ, drains the pipeline, then drives execute's exception_start / irq_start / exception_disable_irqs / irq_fault_address.
- Issues a vectored PC redirect to fetch. SWI and RFE remain branch-class instructions in execute and are not handled here.

Parameters:
- DRAIN_CYCLES, 2, cycles flush is held before entry (1..15).
- CNT_W, 4, drain counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- irq_req  in  1  level IRQ from interrupt controller
- irqs_enabled  in  1  PSR IRQ-enable from execute
- dbg_halt  in  1  debugger stop; masks IRQ acceptance
- data_abort  in  1  pulse from memory stage
- data_pc_plus_4  in  32  pc+4 of aborting load/store
- instr_abort  in  1  pulse, fetch bus error, valid with i_valid
- illegal_instr  in  1  pulse from decode, valid with i_valid
- i_valid  in  1  decode-stage instruction valid
- dec_pc_plus_4  in  32  pc+4 of decode-stage instruction
- irq_pc  in  32  address of next instruction to execute (IRQ return point)
- vector_base  in  26  CR0 vector base from execute
- redirect_ack  in  1  fetch accepted redirect
- flush  out  1  kill fetch/decode/execute contents
- busy  out  1  state != IDLE
- exception_start  out  1  one-cycle pulse, synchronous exception entry
- irq_start  out  1  one-cycle pulse, IRQ entry
- exception_disable_irqs  out  1  one-cycle pulse with either start
- irq_fault_address  out  32  return address for IRQ (valid with irq_start)
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  32  {vector_base, 6'(offset)}
- exc_cause  out  3  latched cause: 1 illegal, 3 IRQ, 4 ifetch abort, 5 data abort, 0 none

Behaviour:
- Reset (async, any state): state=IDLE; all 1-bit outputs 0; redirect_pc, irq_fault_address, exc_cause, counter = 0. Reset mid-sequence abandons entry with no pulses.
- Vector offsets: illegal 0x04, IRQ 0x0c, ifetch abort 0x10, data abort 0x14; SWI 0x08 is reserved to execute.
- Cause qualification: instr_abort/illegal_instr only when i_valid. IRQ only when irq_req && irqs_enabled && !dbg_halt.
- Priority, same cycle: data_abort > instr_abort > illegal_instr > IRQ.
- States IDLE, DRAIN, ENTER, REDIRECT.
- IDLE, qualified cause present (registered next edge):
  - latch exc_cause, redirect_pc and fault address (data_pc_plus_4, dec_pc_plus_4, or irq_pc -> irq_fault_address);
  - flush=1, counter=DRAIN_CYCLES-1, go DRAIN.
- DRAIN:
  - flush=1; counter decrements; at 0 go ENTER.
  - data_abort during DRAIN with latched cause != 5: preempt. Reload cause 5, redirect_pc and fault address, restart counter. It belongs to an older instruction.
  - Other new causes during DRAIN are ignored; they come from flushed instructions, and IRQ stays level-pending.
- ENTER (exactly one cycle):
  - flush=1, exception_disable_irqs=1;
  - irq_start=1 if cause 3, else exception_start=1;
  - redirect_valid=1; go REDIRECT.
- REDIRECT:
  - redirect_valid held with redirect_pc stable until redirect_ack, then IDLE next edge; flush=0.
  - redirect_ack in ENTER also completes: ENTER -> IDLE.
  - New causes are not accepted until IDLE.
- IRQ deasserting after latch still completes entry; the latch is committed.
- irqs_enabled is cleared by execute one cycle after exception_disable_irqs. IDLE therefore ignores IRQ for the cycle after returning from REDIRECT if ENTER was within the last 2 cycles, i.e. no back-to-back re-entry on stale enable.
- busy = state != IDLE.
- Latency, cause to exception_start: DRAIN_CYCLES+1 clocks.

Test Plan:
- IRQ entry: irqs_enabled=1, irq_req=1, irq_pc=0x100, vector_base=0x4 -> flush for 3 cycles; irq_start and exception_disable_irqs pulse 1 cycle at cycle 3; irq_fault_address=0x100; redirect_pc=0x10c; exc_cause=3; IDLE after redirect_ack.
- Priority: data_abort, illegal_instr and irq_req all in one cycle, data_pc_plus_4=0x204 -> exc_cause=5, redirect_pc=base+0x14, exception_start only (no irq_start).
- Preemption: illegal_instr with i_valid, then data_abort 1 cycle later in DRAIN -> cause 5, counter restarts, a single exception_start 3 cycles after the abort.
- Masking: irq_req=1 with irqs_enabled=0, or with dbg_halt=1 -> no flush, busy=0 for 20 cycles; clearing the mask -> entry begins next edge.
- Redirect hold: redirect_ack held low 5 cycles -> redirect_valid and redirect_pc stable; a new illegal_instr in that window is ignored.
- Async reset asserted in DRAIN (between clock edges) -> all outputs 0 immediately; no start pulse afterward.
